// File: rtl/onchip_ram_stream_writer.sv
// Byte-stream to on-chip RAM writer: packs a valid/ready byte stream little-endian
// into 32-bit words and writes them to consecutive word addresses from a programmed base.
//
// state | meaning
// IDLE  | waiting for start; no bytes accepted
// RUN   | packet in progress; accepting bytes and issuing word writes
// LAST  | final (possibly partial) word is on the RAM port; done follows
module onchip_ram_stream_writer #(
    parameter int ADDR_WIDTH = 13,
    parameter int DEPTH      = 5120
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    output logic                  busy,
    output logic                  done,
    output logic                  start_err,
    output logic                  wrapped,
    output logic [ADDR_WIDTH:0]   words_written,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    input  logic                  in_eop,
    output logic                  in_ready,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [3:0]            ram_byteenable,
    output logic                  ram_chipselect,
    output logic                  ram_write,
    output logic [31:0]           ram_writedata
);

    localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, LAST} state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] ptr;
    logic [1:0]            lane;
    logic [31:0]           pack;
    logic [31:0]           merged;
    logic [3:0]            lane_be;
    logic                  xfer;
    logic                  word_done;
    logic                  addr_ok;
    logic                  start_ok;

    assign xfer      = in_valid & in_ready;
    assign word_done = xfer & ((lane == 2'd3) | in_eop);
    assign addr_ok   = {1'b0, start_addr} < DEPTH_W;
    assign start_ok  = (state == IDLE) & start & addr_ok;
    // pack only ever holds lanes below the current one, so unfilled lanes stay zero
    assign merged    = pack | ({24'b0, in_data} << {lane, 3'b000});

    always_comb begin
        lane_be = 4'b1111;
        case (lane)
            2'd0:    lane_be = 4'b0001;
            2'd1:    lane_be = 4'b0011;
            2'd2:    lane_be = 4'b0111;
            default: lane_be = 4'b1111;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_ok) state_nxt = RUN;
            RUN:     if (xfer && in_eop) state_nxt = LAST;
            LAST:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == RUN);
        busy     = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr            <= '0;
            lane           <= '0;
            pack           <= '0;
            done           <= 1'b0;
            start_err      <= 1'b0;
            wrapped        <= 1'b0;
            words_written  <= '0;
            ram_address    <= '0;
            ram_byteenable <= '0;
            ram_chipselect <= 1'b0;
            ram_write      <= 1'b0;
            ram_writedata  <= '0;
        end else begin
            ram_write      <= 1'b0;
            ram_chipselect <= 1'b0;
            done           <= (state == LAST);
            start_err      <= (state == IDLE) & start & ~addr_ok;
            if (start_ok) begin
                ptr           <= start_addr;
                lane          <= '0;
                pack          <= '0;
                wrapped       <= 1'b0;
                words_written <= '0;
            end else if (word_done) begin
                ram_write      <= 1'b1;
                ram_chipselect <= 1'b1;
                ram_address    <= ptr;
                ram_writedata  <= merged;
                ram_byteenable <= lane_be;
                lane           <= '0;
                pack           <= '0;
                if (ptr == LAST_ADDR) begin
                    ptr     <= '0;
                    wrapped <= 1'b1;
                end else begin
                    ptr <= ptr + 1'b1;
                end
                if (words_written != '1)
                    words_written <= words_written + 1'b1;
            end else if (xfer) begin
                pack <= merged;
                lane <= lane + 1'b1;
            end
        end
    end

endmodule

// File: doc/onchip_ram_stream_writer.md
Name: onchip_ram_stream_writer

Overview:
Upstream feeder for the 32-bit single-port on-chip RAM (5120 words, 13-bit word address, byte enables, 1-cycle write, no waitrequest).
- Accepts an 8-bit valid/ready byte stream and packs bytes little-endian into 32-bit words.
- Writes each word to consecutive RAM word addresses, starting at a programmed base.
- Runs one packet per start command; a packet ends on in_eop. A trailing partial word is written with partial byte enables.

Parameters:
ADDR_WIDTH, 13, RAM word-address width.
DEPTH, 5120, RAM depth in words; address wraps from DEPTH-1 to 0.

Ports:
clk  in  1  system clock; all logic on rising edge.
reset  in  1  synchronous, active-high reset.
start  in  1  1-cycle command; begin a packet.
start_addr  in  ADDR_WIDTH  first word address, sampled on accepted start.
busy  out  1  packet in progress.
done  out  1  1-cycle pulse: final word written.
start_err  out  1  1-cycle pulse: start rejected because start_addr >= DEPTH.
wrapped  out  1  sticky: address wrapped during the current/last packet; cleared on accepted start.
words_written  out  ADDR_WIDTH+1  count of RAM write cycles issued for the current/last packet.
in_data  in  8  stream byte.
in_valid  in  1  byte valid.
in_eop  in  1  last byte of packet; qualified by in_valid.
in_ready  out  1  writer can accept a byte.
ram_address  out  ADDR_WIDTH  to RAM address.
ram_byteenable  out  4  to RAM byteenable.
ram_chipselect  out  1  to RAM chipselect.
ram_write  out  1  to RAM write.
ram_writedata  out  32  to RAM writedata.

Behaviour:
- Reset values: busy=0, done=0, start_err=0, wrapped=0, words_written=0, in_ready=0, ram_chipselect=0, ram_write=0, ram_byteenable=0, ram_address=0, ram_writedata=0.
- Reset is honoured in every state. Any partial word is discarded, no write is issued in the cycle after reset, and the FSM returns to IDLE.
- FSM states: IDLE, RUN, LAST.
- IDLE:
  - in_ready=0.
  - start with start_addr < DEPTH: load address pointer, clear byte lane counter, wrapped and words_written, then go to RUN. busy=1 from the next cycle.
  - start with start_addr >= DEPTH: start_err=1 for the next cycle; stay in IDLE.
- RUN:
  - in_ready=1. A byte transfers when in_valid & in_ready.
  - Byte k of the current word (k=0..3) goes to writedata bits [8k+7:8k].
  - On transfer of lane 3 without in_eop: the registered write is presented in the next cycle: ram_write=ram_chipselect=1, byteenable=4'b1111, address=pointer. Then pointer increments (DEPTH-1 -> 0, setting wrapped), words_written increments, and the lane counter clears.
  - Packing of the next word continues in the same cycle the write is presented; the write register is separate from the packing register.
- On transfer with in_eop (any lane k): go to LAST.
  - The final write is presented the next cycle with byteenable = lanes 0..k set: 0001, 0011, 0111 or 1111.
  - Unfilled lanes of writedata are 0.
  - in_ready=0 from the cycle after the eop transfer.
- LAST: after the final write cycle, go to IDLE. In that cycle done=1 and busy=0, and words_written holds its final value.
- Latency: the write appears exactly 1 cycle after the completing byte transfers; done appears 2 cycles after the eop transfer.
- Write strobes (ram_write, ram_chipselect) are high for exactly one cycle per word; otherwise both are 0. Address, data and byteenable are held stable while the strobes are high.
- start while busy is ignored (no error pulse).
- in_valid gaps: there is no timeout, and a partial word is held indefinitely.
- in_eop without in_valid is ignored.
- A packet longer than DEPTH words keeps wrapping and overwrites earlier words. wrapped=1. words_written saturates at its maximum value.

Test Plan:
- Full words: start_addr=0x010, bytes 0x11..0x88 contiguous, eop on 8th -> writes [0x010]=0x44332211 be=F, then [0x011]=0x88776655 be=F; done 2 cycles after eop; words_written=2; wrapped=0.
- Partial tail: 6 bytes 0xA1..0xA6 at addr 0 -> [0]=0xA4A3A2A1 be=F, [1]=0x0000A6A5 be=0011; done pulse; single-byte packet -> be=0001.
- Wrap: start_addr=5119, 8 bytes -> writes at 5119 then 0; wrapped=1; a next start clears wrapped.
- Throttling: in_valid randomly low 50% across a 12-byte packet -> identical RAM writes and data to the contiguous case; strobes only ever 1 cycle wide.
- Reset mid-packet after 2 bytes -> no RAM write issued, busy=0, in_ready=0; a following start at 0x020 with 4 bytes writes only [0x020].
- Command errors: start_addr=5120 -> start_err pulse, busy stays 0; start during RUN -> ignored, packet completes at the original addresses.
